// File: rtl/frame_buffer_sequencer.sv
// Frame buffer sequencer: PLL lock filter, SDRAM frame-buffer ring, image-loader handshake
// with timeout recovery, and frame-boundary buffer swap for the VGA reader.
module frame_buffer_sequencer #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned NUM_BUF        = 2,
  parameter int unsigned FRAME_WORDS    = 76800,
  parameter int unsigned ADDR_W         = 20,
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
  parameter int unsigned HOLD_FRAMES    = 60,
  parameter int unsigned SRC_W          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic              clk_50MHz,
  input  logic              reset_sync_143,
  input  logic              pll_locked,
  input  logic              load_req,
  input  logic [SRC_W-1:0]  src_sel,
  input  logic              auto_cycle,
  input  logic              frame_start,
  input  logic              loader_done,
  output logic              loader_start,
  output logic [SRC_W-1:0]  loader_src,
  output logic [ADDR_W-1:0] write_base_addr,
  output logic [ADDR_W-1:0] read_base_addr,
  output logic              display_valid,
  output logic              fault,
  output logic [3:0]        status_leds
);

  localparam int unsigned BUF_W  = $clog2(NUM_BUF);
  localparam int unsigned LOCK_W = $clog2(LOCK_FILTER + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [LOCK_W-1:0] LockMax  = LOCK_W'(LOCK_FILTER);
  localparam logic [TO_W-1:0]   ToLast   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [BUF_W-1:0]  BufLast  = BUF_W'(NUM_BUF - 1);
  localparam logic [SRC_W-1:0]  SrcLast  = SRC_W'(NUM_SRC - 1);

  typedef enum logic [2:0] {
    StLockWait = 3'd0,
    StLoad     = 3'd1,
    StWaitSwap = 3'd2,
    StDisplay  = 3'd3,
    StFault    = 3'd4
  } state_e;

  state_e              state_q;
  logic [LOCK_W-1:0]   lock_cnt_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [BUF_W-1:0]    disp_buf_q;
  logic [SRC_W-1:0]    last_src_q;
  logic                pend_q;
  logic [SRC_W-1:0]    pend_src_q;

  logic [BUF_W-1:0]    wr_buf;
  logic [SRC_W-1:0]    req_src;
  logic [SRC_W-1:0]    auto_src;
  logic                lock_lost;
  logic                load_go;
  logic [SRC_W-1:0]    load_src;

  function automatic logic [ADDR_W-1:0] buf_base(input logic [BUF_W-1:0] b);
    return ADDR_W'(32'(b) * FRAME_WORDS);
  endfunction

  assign wr_buf    = (disp_buf_q == BufLast) ? '0 : disp_buf_q + 1'b1;
  assign req_src   = (32'(src_sel) >= NUM_SRC) ? SrcLast : src_sel;
  assign auto_src  = (last_src_q == SrcLast) ? '0 : last_src_q + 1'b1;
  assign lock_lost = (state_q != StLockWait) && !pll_locked;

  assign status_leds = {fault, 3'(state_q)};

  // Decide whether a new load starts this cycle and which source it uses.
  // A live load_req always beats an older pending request (last request wins).
  always_comb begin
    load_go  = 1'b0;
    load_src = last_src_q;
    case (state_q)
      StLockWait: begin
        if (pll_locked && lock_cnt_q == LockMax) begin
          load_go  = 1'b1;
          load_src = load_req ? req_src : (pend_q ? pend_src_q : last_src_q);
        end
      end
      StDisplay: begin
        if (pll_locked) begin
          if (load_req) begin
            load_go  = 1'b1;
            load_src = req_src;
          end else if (pend_q) begin
            load_go  = 1'b1;
            load_src = pend_src_q;
          end else if (auto_cycle && frame_start && hold_cnt_q == HoldLast) begin
            load_go  = 1'b1;
            load_src = auto_src;
          end
        end
      end
      StFault: begin
        if (pll_locked && load_req) begin
          load_go  = 1'b1;
          load_src = req_src;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_sync_143) begin
    if (!reset_sync_143) begin
      state_q         <= StLockWait;
      lock_cnt_q      <= '0;
      to_cnt_q        <= '0;
      hold_cnt_q      <= '0;
      disp_buf_q      <= BufLast;
      last_src_q      <= '0;
      pend_q          <= 1'b0;
      pend_src_q      <= '0;
      loader_start    <= 1'b0;
      loader_src      <= '0;
      write_base_addr <= '0;
      read_base_addr  <= buf_base(BufLast);
      display_valid   <= 1'b0;
      fault           <= 1'b0;
    end else begin
      if (load_req && (state_q == StLockWait || state_q == StLoad || state_q == StWaitSwap)) begin
        pend_q     <= 1'b1;
        pend_src_q <= req_src;
      end

      if (lock_lost) begin
        // Abandon any partial write; the displayed buffer stays untouched.
        state_q      <= StLockWait;
        lock_cnt_q   <= '0;
        loader_start <= 1'b0;
      end else if (load_go) begin
        state_q         <= StLoad;
        loader_start    <= 1'b1;
        loader_src      <= load_src;
        last_src_q      <= load_src;
        write_base_addr <= buf_base(wr_buf);
        to_cnt_q        <= '0;
        fault           <= 1'b0;
        pend_q          <= 1'b0;
      end else begin
        case (state_q)
          StLockWait: begin
            if (!pll_locked) begin
              lock_cnt_q <= '0;
            end else if (lock_cnt_q != LockMax) begin
              lock_cnt_q <= lock_cnt_q + 1'b1;
            end
          end
          StLoad: begin
            if (loader_done) begin
              state_q      <= StWaitSwap;
              loader_start <= 1'b0;
            end else if (to_cnt_q == ToLast) begin
              state_q      <= StFault;
              loader_start <= 1'b0;
              fault        <= 1'b1;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          StWaitSwap: begin
            if (frame_start) begin
              disp_buf_q     <= wr_buf;
              read_base_addr <= buf_base(wr_buf);
              display_valid  <= 1'b1;
              hold_cnt_q     <= '0;
              state_q        <= StDisplay;
            end
          end
          StDisplay: begin
            if (auto_cycle && frame_start) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_buffer_sequencer.sv
// Self-checking bench for frame_buffer_sequencer: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural model of the sequencing rules.
module tb_frame_buffer_sequencer;

  localparam int unsigned NumSrc        = 4;
  localparam int unsigned NumBuf        = 2;
  localparam int unsigned FrameWords    = 76800;
  localparam int unsigned AddrW         = 20;
  localparam int unsigned LockFilter    = 16;
  localparam int unsigned TimeoutCycles = 1000;
  localparam int unsigned HoldFrames    = 3;
  localparam int unsigned SrcW          = 2;

  logic             clk_50MHz = 1'b0;
  logic             reset_sync_143 = 1'b1;
  logic             pll_locked = 1'b0;
  logic             load_req = 1'b0;
  logic [SrcW-1:0]  src_sel = '0;
  logic             auto_cycle = 1'b0;
  logic             frame_start = 1'b0;
  logic             loader_done = 1'b0;
  logic             loader_start;
  logic [SrcW-1:0]  loader_src;
  logic [AddrW-1:0] write_base_addr;
  logic [AddrW-1:0] read_base_addr;
  logic             display_valid;
  logic             fault;
  logic [3:0]       status_leds;

  always #10 clk_50MHz = ~clk_50MHz;

  frame_buffer_sequencer #(
    .NUM_SRC        (NumSrc),
    .NUM_BUF        (NumBuf),
    .FRAME_WORDS    (FrameWords),
    .ADDR_W         (AddrW),
    .LOCK_FILTER    (LockFilter),
    .TIMEOUT_CYCLES (TimeoutCycles),
    .HOLD_FRAMES    (HoldFrames),
    .SRC_W          (SrcW)
  ) dut (
    .clk_50MHz       (clk_50MHz),
    .reset_sync_143  (reset_sync_143),
    .pll_locked      (pll_locked),
    .load_req        (load_req),
    .src_sel         (src_sel),
    .auto_cycle      (auto_cycle),
    .frame_start     (frame_start),
    .loader_done     (loader_done),
    .loader_start    (loader_start),
    .loader_src      (loader_src),
    .write_base_addr (write_base_addr),
    .read_base_addr  (read_base_addr),
    .display_valid   (display_valid),
    .fault           (fault),
    .status_leds     (status_leds)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model. Phase codes: 0 lock wait, 1 loading, 2 waiting for swap,
  // 3 displaying, 4 faulted.
  int m_phase, m_run, m_to, m_hold, m_disp, m_last, m_pend, m_pend_src;
  int m_fault, m_valid, m_start, m_src, m_wbase, m_rbase;

  task automatic model_reset();
    m_phase = 0; m_run = 0; m_to = 0; m_hold = 0;
    m_disp = NumBuf - 1; m_last = 0; m_pend = 0; m_pend_src = 0;
    m_fault = 0; m_valid = 0; m_start = 0; m_src = 0;
    m_wbase = 0; m_rbase = (NumBuf - 1) * FrameWords;
  endtask

  task automatic model_step();
    int req;
    int nsrc;
    bit go;
    req  = (int'(src_sel) > NumSrc - 1) ? NumSrc - 1 : int'(src_sel);
    go   = 1'b0;
    nsrc = 0;
    if (load_req && m_phase <= 2) begin
      m_pend = 1;
      m_pend_src = req;
    end
    if (m_phase != 0 && !pll_locked) begin
      m_phase = 0;
      m_run   = 0;
      m_start = 0;
    end else begin
      case (m_phase)
        0: begin
          m_run = pll_locked ? m_run + 1 : 0;
          if (m_run > LockFilter) begin
            go = 1'b1;
            nsrc = m_pend ? m_pend_src : m_last;
          end
        end
        1: begin
          if (loader_done) begin
            m_phase = 2;
            m_start = 0;
          end else begin
            m_to++;
            if (m_to == TimeoutCycles) begin
              m_phase = 4;
              m_fault = 1;
              m_start = 0;
            end
          end
        end
        2: begin
          if (frame_start) begin
            m_disp  = (m_disp + 1) % NumBuf;
            m_rbase = m_disp * FrameWords;
            m_valid = 1;
            m_hold  = 0;
            m_phase = 3;
          end
        end
        3: begin
          if (load_req) begin
            go = 1'b1; nsrc = req;
          end else if (m_pend) begin
            go = 1'b1; nsrc = m_pend_src;
          end else if (auto_cycle && frame_start) begin
            m_hold++;
            if (m_hold == HoldFrames) begin
              go = 1'b1;
              nsrc = (m_last + 1) % NumSrc;
            end
          end
        end
        4: begin
          if (load_req) begin
            go = 1'b1; nsrc = req;
          end
        end
        default: ;
      endcase
    end
    if (go) begin
      m_phase = 1; m_start = 1; m_src = nsrc; m_last = nsrc;
      m_wbase = ((m_disp + 1) % NumBuf) * FrameWords;
      m_to = 0; m_fault = 0; m_pend = 0;
    end
  endtask

  task automatic compare();
    check_eq("loader_start", loader_start, m_start);
    check_eq("loader_src", loader_src, m_src);
    check_eq("write_base_addr", write_base_addr, m_wbase);
    check_eq("read_base_addr", read_base_addr, m_rbase);
    check_eq("display_valid", display_valid, m_valid);
    check_eq("fault", fault, m_fault);
    check_eq("status_leds", status_leds, m_fault * 8 + m_phase);
  endtask

  task automatic step();
    @(posedge clk_50MHz);
    model_step();
    #1;
    compare();
  endtask

  task automatic pulse_done();
    loader_done = 1'b1; step(); loader_done = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1; step(); frame_start = 1'b0;
  endtask

  int n;
  int exp_auto[4] = '{1, 2, 3, 0};

  initial begin
    // Reset values.
    #2 reset_sync_143 = 1'b0;
    model_reset();
    #1 compare();
    @(posedge clk_50MHz);
    #1 reset_sync_143 = 1'b1;

    // Lock filter: a single low sample restarts the count.
    pll_locked = 1'b1;
    repeat (15) step();
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    n = 0;
    while (!loader_start && n < 40) begin step(); n++; end
    check_eq("lock_latency", n, 17);
    check_eq("first_wbase", write_base_addr, 0);
    check_eq("first_src", loader_src, 0);

    // Queued requests during the first load; the later one wins.
    repeat (3) step();
    load_req = 1'b1; src_sel = 2; step(); load_req = 1'b0;
    step();
    load_req = 1'b1; src_sel = 3; step(); load_req = 1'b0;
    repeat (3) step();
    pulse_done();
    check_eq("wait_swap_state", status_leds[2:0], 2);
    check_eq("rbase_before_swap", read_base_addr, 76800);
    repeat (4) step();
    pulse_frame();
    check_eq("swap_rbase", read_base_addr, 0);
    check_eq("swap_valid", display_valid, 1);
    check_eq("swap_state", status_leds[2:0], 3);
    step();
    check_eq("queued_start", loader_start, 1);
    check_eq("queued_src", loader_src, 3);
    check_eq("queued_wbase", write_base_addr, 76800);

    // Lock loss during the second load.
    repeat (5) step();
    pll_locked = 1'b0;
    step();
    check_eq("lost_start", loader_start, 0);
    check_eq("lost_rbase", read_base_addr, 0);
    check_eq("lost_valid", display_valid, 1);
    pll_locked = 1'b1;
    n = 0;
    while (!loader_start && n < 40) begin step(); n++; end
    check_eq("relock_latency", n, 17);
    check_eq("relock_src", loader_src, 3);

    // Timeout with no loader_done.
    n = 0;
    while (!fault && n < 1100) begin step(); n++; end
    check_eq("timeout_cycles", n, 1000);
    check_eq("timeout_leds", status_leds, 4'b1100);
    check_eq("timeout_start", loader_start, 0);
    repeat (3) step();
    load_req = 1'b1; src_sel = 0; step(); load_req = 1'b0;
    check_eq("recover_fault", fault, 0);
    check_eq("recover_start", loader_start, 1);
    check_eq("recover_src", loader_src, 0);
    repeat (2) step();
    pulse_done();
    repeat (2) step();
    pulse_frame();
    check_eq("recover_rbase", read_base_addr, 76800);

    // Auto-cycle rotation.
    auto_cycle = 1'b1;
    foreach (exp_auto[k]) begin
      for (int f = 0; f < 3; f++) begin
        repeat (2) step();
        pulse_frame();
      end
      check_eq("auto_start", loader_start, 1);
      check_eq("auto_src", loader_src, exp_auto[k]);
      repeat (3) step();
      pulse_done();
      repeat (2) step();
      pulse_frame();
    end
    // A request coinciding with the third frame wins over the rotation.
    for (int f = 0; f < 2; f++) begin
      repeat (2) step();
      pulse_frame();
    end
    repeat (2) step();
    load_req = 1'b1; src_sel = 2; frame_start = 1'b1;
    step();
    load_req = 1'b0; frame_start = 1'b0;
    check_eq("coincide_src", loader_src, 2);

    // Asynchronous reset while loading.
    repeat (3) step();
    #3 reset_sync_143 = 1'b0;
    model_reset();
    #1 compare();
    check_eq("areset_leds", status_leds, 0);
    @(posedge clk_50MHz);
    #1 reset_sync_143 = 1'b1;

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      pll_locked  = ($urandom_range(0, 299) != 0);
      load_req    = ($urandom_range(0, 39) == 0);
      src_sel     = SrcW'($urandom);
      loader_done = ($urandom_range(0, 24) == 0);
      frame_start = ($urandom_range(0, 14) == 0);
      if ($urandom_range(0, 199) == 0) auto_cycle = ~auto_cycle;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
